fpaccum: RTL and testbench

//   Streaming fixed-point accumulator directly downstream of the iterative fixed-point multiplier.
//   - Consumes the multiplier's product stream over a val/rdy handshake.
//   - Sums a batch of len products (or fewer, if ended early by snd_last) in a widened register.
//   - Emits one saturated n-bit sum per batch. Forms the dot-product/MAC back end of the datapath.

---
 rtl/fpaccum_pkg.sv | 11 +
 rtl/fpaccum_sat.sv | 29 ++
 rtl/fpaccum.sv | 87 ++++++++
 tb/tb_fpaccum.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpaccum_pkg.sv
// fpaccum_pkg: shared FSM state type and accumulator sizing for fpaccum
package fpaccum_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    // Headroom for len worst-case products plus one guard bit for the sign.
    function automatic int acc_width(input int n, input int len);
        return n + $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/fpaccum_sat.sv
// fpaccum_sat: combinational clamp of a wide sum to n bits with overflow flag
module fpaccum_sat #(
    parameter int n    = 32,
    parameter int w    = 36,
    parameter int sign = 1
) (
    input  logic [w-1:0] s,
    output logic [n-1:0] c,
    output logic         ovf
);

    logic pos;
    logic neg;

    // Signed: in range only when bits [w-1:n-1] are all copies of the sign bit.
    if (sign != 0) begin : g_s
        assign pos = !s[w-1] && |s[w-2:n-1];
        assign neg = s[w-1] && !(&s[w-2:n-1]);
    end else begin : g_u
        assign pos = |s[w-1:n];
        assign neg = 1'b0;
    end

    assign ovf = pos | neg;
    assign c   = pos ? (sign != 0 ? {1'b0, {(n-1){1'b1}}} : {n{1'b1}})
               : neg ? {1'b1, {(n-1){1'b0}}}
               : s[n-1:0];

endmodule

// File: rtl/fpaccum.sv
// fpaccum: streaming batch accumulator with saturated n-bit sum per batch
module fpaccum
    import fpaccum_pkg::*;
#(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int sign = 1,
    parameter int len  = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         snd_val,
    output logic         snd_rdy,
    input  logic         snd_last,
    input  logic [n-1:0] a,
    output logic         rcv_val,
    input  logic         rcv_rdy,
    output logic [n-1:0] c,
    output logic         ovf
);

    localparam int w  = acc_width(n, len);
    localparam int cw = $clog2(len + 1);
    localparam logic [cw-1:0] last_cnt = cw'(len - 1);

    if (len < 2 || d > n) begin : g_bad_params
        $error("fpaccum: need len >= 2 and d <= n");
    end

    state_t        state;
    state_t        state_n;
    logic [w-1:0]  acc;
    logic [w-1:0]  a_ext;
    logic [w-1:0]  sum;
    logic [cw-1:0] cnt;
    logic          accept;
    logic          close;
    logic          out_hs;
    logic [n-1:0]  sat_c;
    logic          sat_ovf;

    assign snd_rdy = state != DONE;
    assign rcv_val = state == DONE;
    assign a_ext   = {{(w-n){sign != 0 && a[n-1]}}, a};
    // acc is zero whenever IDLE, so one adder serves both first and later accepts
    assign sum     = acc + a_ext;

    always_comb begin
        accept  = snd_val & snd_rdy;
        close   = accept & (snd_last | cnt == last_cnt);
        out_hs  = rcv_val & rcv_rdy;
        state_n = state == DONE ? (rcv_rdy ? IDLE : DONE)
                : close ? DONE
                : accept ? ACCUM
                : state;
    end

    fpaccum_sat #(.n(n), .w(w), .sign(sign)) u_sat (
        .s   (sum),
        .c   (sat_c),
        .ovf (sat_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            c     <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (out_hs) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
            if (close) begin
                c   <= sat_c;
                ovf <= sat_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fpaccum.sv
// tb_fpaccum: directed and random scoreboard checks of fpaccum (signed and unsigned)
module tb_fpaccum;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        snd_val = 1'b0;
    logic        snd_last = 1'b0;
    logic [31:0] a = '0;
    logic        rcv_rdy = 1'b0;
    logic        snd_rdy;
    logic        rcv_val;
    logic [31:0] c;
    logic        ovf;

    logic        uval = 1'b0;
    logic [31:0] ua = '0;
    logic        urcv_rdy = 1'b0;
    logic        urdy;
    logic        urcv_val;
    logic [31:0] uc;
    logic        uovf;

    int          total = 0;
    int          bad = 0;
    bit          rnd = 0;
    longint      msum = 0;
    int          mcnt = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    fpaccum #(.n(32), .d(16), .sign(1), .len(4)) dut (
        .clk(clk), .reset_n(reset_n), .snd_val(snd_val), .snd_rdy(snd_rdy),
        .snd_last(snd_last), .a(a), .rcv_val(rcv_val), .rcv_rdy(rcv_rdy),
        .c(c), .ovf(ovf)
    );

    fpaccum #(.n(32), .d(16), .sign(0), .len(4)) dut_u (
        .clk(clk), .reset_n(reset_n), .snd_val(uval), .snd_rdy(urdy),
        .snd_last(1'b0), .a(ua), .rcv_val(urcv_val), .rcv_rdy(urcv_rdy),
        .c(uc), .ovf(uovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] sat_ref(input longint s);
        if (s > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        if (s < -64'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, s[31:0]};
    endfunction

    // Present one product; returns #1 after the edge that accepted it.
    task automatic send(input logic [31:0] v, input logic l);
        int k = 0;
        bit ok = 0;
        snd_val = 1'b1;
        a = v;
        snd_last = l;
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = snd_rdy;
            @(posedge clk);
            #1;
            if (rnd) rcv_rdy = 1'($urandom_range(0, 1));
            k++;
        end
        snd_val = 1'b0;
        snd_last = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
        if (ok) begin
            msum += longint'($signed(v));
            mcnt++;
            if (l || mcnt == 4) begin
                exp_q.push_back(sat_ref(msum));
                msum = 0;
                mcnt = 0;
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic usend4(input logic [31:0] v, input logic [31:0] ec, input logic eo);
        @(posedge clk);
        #1;
        uval = 1'b1;
        ua = v;
        repeat (4) @(posedge clk);
        #1;
        uval = 1'b0;
        chk("u_rcv_val", 64'(urcv_val), 64'd1);
        chk("u_c", 64'(uc), 64'(ec));
        chk("u_ovf", 64'(uovf), 64'(eo));
        urcv_rdy = 1'b1;
        @(posedge clk);
        #1;
        urcv_rdy = 1'b0;
        chk("u_idle", 64'(urdy), 64'd1);
    endtask

    always @(negedge clk) begin
        if (reset_n && rcv_val && rcv_rdy) begin
            if (exp_q.size() == 0) chk("unexpected_output", {31'd0, ovf, c}, 64'hDEAD);
            else chk("sum", {31'd0, ovf, c}, {31'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #3;
        chk("rst_snd_rdy", 64'(snd_rdy), 64'd1);
        chk("rst_rcv_val", 64'(rcv_val), 64'd0);
        chk("rst_c", 64'(c), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // basic sum and one-cycle latency
        rcv_rdy = 1'b1;
        send(32'h00018000, 0);
        send(32'h00024000, 0);
        send(32'hFFFF4000, 0);
        chk("lat_before", 64'(rcv_val), 64'd0);
        send(32'h00008000, 0);
        chk("lat_after", 64'(rcv_val), 64'd1);
        chk("basic_c", 64'(c), 64'h00038000);
        drain();

        // saturation both ways and recovery inside the wide sum
        repeat (4) send(32'h7FFF0000, 0);
        drain();
        repeat (4) send(32'h80000000, 0);
        drain();
        send(32'h7FFF0000, 0);
        send(32'h7FFF0000, 0);
        send(32'h80010000, 0);
        send(32'h80010000, 0);
        drain();

        // early end, then snd_last without snd_val ignored, then last on len-th
        send(32'h00020000, 0);
        send(32'h00030000, 1);
        drain();
        snd_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        snd_last = 1'b0;
        chk("last_no_val", 64'(rcv_val), 64'd0);
        repeat (4) send(32'h00010000, 0);
        drain();
        repeat (3) send(32'h00010000, 0);
        send(32'h00010000, 1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("no_double", 64'(rcv_val), 64'd0);

        // backpressure in DONE with an upstream product held
        rcv_rdy = 1'b0;
        repeat (4) send(32'h00010000, 0);
        snd_val = 1'b1;
        a = 32'h99999999;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rcv_val", 64'(rcv_val), 64'd1);
            chk("bp_snd_rdy", 64'(snd_rdy), 64'd0);
            chk("bp_c", 64'(c), 64'h00040000);
        end
        @(posedge clk);
        #1;
        snd_val = 1'b0;
        rcv_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_rdy", 64'(snd_rdy), 64'd1);
        chk("bp_idle_val", 64'(rcv_val), 64'd0);
        chk("bp_popped", 64'(exp_q.size()), 64'd0);

        // asynchronous reset mid-batch
        send(32'h00050000, 0);
        send(32'h00070000, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_snd_rdy", 64'(snd_rdy), 64'd1);
        chk("mid_rst_rcv_val", 64'(rcv_val), 64'd0);
        chk("mid_rst_c", 64'(c), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        msum = 0;
        mcnt = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) send(32'h00010000, 0);
        drain();

        // unsigned instance
        usend4(32'h3FFFFFFF, 32'hFFFFFFFC, 1'b0);
        usend4(32'hC0000000, 32'hFFFFFFFF, 1'b1);

        // random back-to-back batches with random gaps and backpressure
        rnd = 1;
        for (int i = 0; i < 120; i++) begin
            logic [31:0] v;
            v = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 32'h000FFFFF)) - 32'sh00080000);
            send(v, 1'($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                rcv_rdy = 1'($urandom_range(0, 1));
            end
        end
        rnd = 0;
        if (mcnt != 0) send(32'h00000001, 1);
        rcv_rdy = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
